neopix_frame_sched: RTL and testbench
=====================================

# neopix_frame_sched

Frame scheduler for the SPI-to-NeoPixel path. It owns the ping-pong bank assignment of the pixel dual-port RAM. It grants one bank to the SPI frame writer and hands the other to the ws2812 driver. On each committed frame it swaps the banks and starts the driver. It also enforces the WS2812 latch gap between transmissions.

## Interface
- `NUM_LEDS`, 8: LEDs per bank; `CW = $clog2(NUM_LEDS)+1`
- `SYSTEM_CLOCK`, 50000000: clk_i frequency in Hz
- `LATCH_US`, 80: minimum low time after a transmission; `LATCH_CYCLES = SYSTEM_CLOCK/1000000*LATCH_US`
- `REFRESH_HZ`, 30: periodic re-send rate; `REFRESH_CYCLES = SYSTEM_CLOCK/REFRESH_HZ`; used only with the macro
- `clk_i` in 1: single clock
- `reset_n_i` in 1: synchronous, active-low reset
- `wr_begin_i` in 1: one-cycle pulse; the writer requests a bank (SSEL falling edge)
- `wr_commit_i` in 1: one-cycle pulse; the writer has finished its frame (SSEL rising edge)
- `wr_count_i` in CW: number of LEDs written; sampled with `wr_commit_i`
- `wr_bank_o` out 1: bank the writer must address
- `wr_grant_o` out 1: high while the writer may write `wr_bank_o`
- `ws_busy_i` in 1: busy flag from the ws2812 driver
- `ws_start_o` out 1: one-cycle start pulse to the driver
- `ws_bank_o` out 1: bank the driver reads
- `ws_count_o` out CW: LED count for the driver
- `err_o` out 1: one-cycle pulse when a commit is rejected
- `sched_busy_o` out 1: high in any state other than IDLE

## Operation
- **Reset values:** `wr_bank_o=0`, `ws_bank_o=1`, `ws_count_o=0`, `wr_grant_o=0`, `ws_start_o=0`, `err_o=0`, `sched_busy_o=0`. Internal: `pending=0`, `begin_wait=0`, `valid=0`, state IDLE.
- **Bank invariant:** `wr_bank_o != ws_bank_o` at all times. Both outputs change only in SWAP.
- **wr_begin_i:**
  - If `pending=0`, `wr_grant_o` goes to 1 on the next edge.
  - If `pending=1`, `begin_wait` is set, and the grant is issued in START.
  - A begin while already granted has no effect.
- **wr_commit_i with grant high and `wr_count_i != 0`:**
  - `pending <= 1` and `pend_count <= min(wr_count_i, NUM_LEDS)`.
  - `wr_grant_o <= 0`.
- **Rejected commits:** a commit with grant low, or with `wr_count_i == 0`, pulses `err_o` and clears the grant. No other state changes.
- **Begin and commit in the same cycle:** the commit is processed first. The begin then sees `pending=1` and waits.
- **FSM states:**
  - IDLE: `pending` -> SWAP. Otherwise `refresh_req && valid` -> START (macro only).
  - SWAP (1 cycle): `ws_bank_o <= wr_bank_o`, `wr_bank_o <= ~wr_bank_o`, `ws_count_o <= pend_count`, `valid <= 1`. Clears `pending` and `refresh_req`. -> START.
  - START (1 cycle): `ws_start_o = 1`. If `begin_wait`, then `wr_grant_o <= 1` and `begin_wait` is cleared. -> DRIVE.
  - DRIVE: waits for `ws_busy_i` to be seen high and then low. If busy is not seen high within 4 cycles of START, the transmission is treated as done. -> LATCH.
  - LATCH: down-counts `LATCH_CYCLES`. On reaching 0 -> IDLE.
- **Commits during DRIVE or LATCH** are queued in `pending`; only one is held. The writer cannot overwrite it because it has no grant until START.
- **Reset mid-operation:** all state returns to reset values next edge. No `ws_start_o` pulse is emitted.

## Timing
- Commit sampled at edge N with the FSM in IDLE: SWAP is the cycle after N+1, and `ws_start_o` is high in the cycle after N+2.
- `ws_bank_o` and `ws_count_o` are valid in the START cycle and stay stable until the next SWAP.
- A granted writer sees `wr_grant_o` high one cycle after `wr_begin_i`. A waiting writer sees it in the START cycle.
- Minimum start-to-start spacing = driver busy time + `LATCH_CYCLES` + 2.

## Configuration
- `NEOPIX_REFRESH_EN` defined:
  - A free-running counter of `REFRESH_CYCLES` sets `refresh_req` on wrap. It stays set until serviced.
  - IDLE re-sends the current `ws_bank_o` when `valid=1`, with no swap.
  - A pending commit has priority and clears `refresh_req`.
- Undefined: no timer and no `refresh_req`; the driver starts only on commits.

## Structure
- Package `neopix_pkg`: FSM state encoding (IDLE, SWAP, START, DRIVE, LATCH), the `CW` width function, and cycle-count constant functions.
- One sub-module, `neopix_tick_timer`: a parameterised down-counter with load and terminal-count pulse. It is instantiated for the latch gap and, under the macro, for the refresh tick.

## Test plan
Bench parameters: `SYSTEM_CLOCK=1000000`, `LATCH_US=80` (80 cycles), `REFRESH_HZ=1000` (1000 cycles), `NUM_LEDS=8`.
1. Reset, then begin, then commit with count 8 -> `ws_start_o` pulses 3 cycles after the commit edge, `ws_bank_o=0`, `wr_bank_o=1`, `ws_count_o=8`.
2. Commit with no grant, and a commit with count 0 -> one `err_o` pulse each; no swap; `ws_start_o` stays low.
3. Second commit during DRIVE with busy held 200 cycles -> the next start comes exactly 80+2 cycles after busy falls, with banks swapped back.
4. Begin while pending -> `wr_grant_o` stays low until the START cycle; count 12 is clamped so that `ws_count_o=8`.
5. With `NEOPIX_REFRESH_EN` and no commits after frame 1 -> `ws_start_o` every 1000 cycles, `ws_bank_o` unchanged; `valid=0` after reset gives no starts.
6. `reset_n_i` low during LATCH and during START -> all outputs at reset values the next cycle; no stray start pulse.

Source files
------------

// File: rtl/neopix_pkg.sv
// Shared types and elaboration-time helpers for the NeoPixel frame scheduler.
package neopix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWAP,
    ST_START,
    ST_DRIVE,
    ST_LATCH
  } state_e;

  // How many DRIVE cycles to wait for the driver to raise busy before giving up.
  localparam int DRIVE_TIMEOUT = 4;

  function automatic int cw_f(input int num_leds);
    return $clog2(num_leds) + 1;
  endfunction

  function automatic int cnt_width_f(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int latch_cycles_f(input int sys_clk, input int latch_us);
    return sys_clk / 1000000 * latch_us;
  endfunction

  function automatic int refresh_cycles_f(input int sys_clk, input int refresh_hz);
    return sys_clk / refresh_hz;
  endfunction

endpackage

// File: rtl/neopix_tick_timer.sv
// Reloadable down-counter: tc_o pulses while enabled at zero, then the count reloads.
module neopix_tick_timer
  import neopix_pkg::*;
#(
  parameter int LOAD_VAL = 1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = cnt_width_f(LOAD_VAL);
  localparam logic [W-1:0] LOAD = W'(LOAD_VAL);

  logic [W-1:0] count_q;

  assign tc_o = en_i && !load_i && (count_q == '0);

  // Period is LOAD_VAL+1 enabled cycles when left free-running.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= LOAD;
    end else if (load_i) begin
      count_q <= LOAD;
    end else if (en_i) begin
      count_q <= (count_q == '0) ? LOAD : count_q - 1'b1;
    end
  end

endmodule

// File: rtl/neopix_frame_sched.sv
// Ping-pong bank scheduler between the SPI frame writer and the ws2812 driver.
// Define NEOPIX_REFRESH_EN to re-send the last frame every REFRESH_CYCLES.
module neopix_frame_sched
  import neopix_pkg::*;
#(
  parameter int  NUM_LEDS     = 8,
  parameter int  SYSTEM_CLOCK = 50000000,
  parameter int  LATCH_US     = 80,
  parameter int  REFRESH_HZ   = 30,
  localparam int CW           = cw_f(NUM_LEDS)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          wr_begin_i,
  input  logic          wr_commit_i,
  input  logic [CW-1:0] wr_count_i,
  output logic          wr_bank_o,
  output logic          wr_grant_o,
  input  logic          ws_busy_i,
  output logic          ws_start_o,
  output logic          ws_bank_o,
  output logic [CW-1:0] ws_count_o,
  output logic          err_o,
  output logic          sched_busy_o
);

  localparam int LATCH_CYCLES = latch_cycles_f(SYSTEM_CLOCK, LATCH_US);
  // The DRIVE cycle that sees busy fall already counts as the first low cycle.
  localparam int LATCH_LOAD = (LATCH_CYCLES > 2) ? LATCH_CYCLES - 2 : 0;
  localparam logic [CW-1:0] MAX_COUNT = CW'(NUM_LEDS);

  if (LATCH_CYCLES < 2 || REFRESH_HZ < 1) begin : g_cfg_check
    $error("neopix_frame_sched: LATCH_US or REFRESH_HZ out of range");
  end

  state_e        state_q;
  logic          wr_bank_q, ws_bank_q, grant_q, start_q, err_q;
  logic          pending_q, begin_wait_q, seen_busy_q;
  logic [CW-1:0] pend_count_q, ws_count_q;
  logic [1:0]    drv_cnt_q;
  logic          grant_d, pending_d, begin_wait_d, err_d;
  logic [CW-1:0] pend_count_d;
  logic          commit_ok, latch_done, refresh_go;

  // Writer handshake: a commit is resolved before a same-cycle begin looks at pending.
  always_comb begin
    commit_ok    = wr_commit_i && grant_q && (wr_count_i != '0);
    grant_d      = grant_q;
    pending_d    = pending_q;
    begin_wait_d = begin_wait_q;
    pend_count_d = pend_count_q;
    err_d        = 1'b0;
    if (wr_commit_i) begin
      grant_d = 1'b0;
      if (commit_ok) begin
        pending_d    = 1'b1;
        pend_count_d = (wr_count_i > MAX_COUNT) ? MAX_COUNT : wr_count_i;
      end else begin
        err_d = 1'b1;
      end
    end
    if (wr_begin_i && !grant_d) begin
      if (pending_d) begin_wait_d = 1'b1;
      else           grant_d      = 1'b1;
    end
  end

  neopix_tick_timer #(.LOAD_VAL(LATCH_LOAD)) u_latch_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (state_q != ST_LATCH),
    .en_i      (state_q == ST_LATCH),
    .tc_o      (latch_done)
  );

`ifdef NEOPIX_REFRESH_EN
  logic valid_q, refresh_req_q, refresh_tick;

  neopix_tick_timer #(.LOAD_VAL(refresh_cycles_f(SYSTEM_CLOCK, REFRESH_HZ) - 1)) u_refresh_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (1'b0),
    .en_i      (1'b1),
    .tc_o      (refresh_tick)
  );

  // A refresh request survives until a swap or a re-send consumes it.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid_q       <= 1'b0;
      refresh_req_q <= 1'b0;
    end else begin
      if (state_q == ST_SWAP) valid_q <= 1'b1;
      if (state_q == ST_SWAP || (state_q == ST_IDLE && refresh_go)) refresh_req_q <= 1'b0;
      else if (refresh_tick)                                          refresh_req_q <= 1'b1;
    end
  end

  assign refresh_go = !pending_q && refresh_req_q && valid_q;
`else
  assign refresh_go = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      wr_bank_q    <= 1'b0;
      ws_bank_q    <= 1'b1;
      ws_count_q   <= '0;
      grant_q      <= 1'b0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
      pending_q    <= 1'b0;
      begin_wait_q <= 1'b0;
      pend_count_q <= '0;
      seen_busy_q  <= 1'b0;
      drv_cnt_q    <= '0;
    end else begin
      grant_q      <= grant_d;
      pending_q    <= pending_d;
      begin_wait_q <= begin_wait_d;
      pend_count_q <= pend_count_d;
      err_q        <= err_d;
      start_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            state_q <= ST_SWAP;
          end else if (refresh_go) begin
            state_q <= ST_START;
            start_q <= 1'b1;
          end
        end
        ST_SWAP: begin
          ws_bank_q  <= wr_bank_q;
          wr_bank_q  <= ~wr_bank_q;
          ws_count_q <= pend_count_q;
          pending_q  <= 1'b0;
          start_q    <= 1'b1;
          state_q    <= ST_START;
          // A waiting writer must see its grant in the START cycle.
          if (begin_wait_d) begin
            grant_q      <= 1'b1;
            begin_wait_q <= 1'b0;
          end
        end
        ST_START: begin
          drv_cnt_q   <= '0;
          seen_busy_q <= 1'b0;
          state_q     <= ST_DRIVE;
        end
        ST_DRIVE: begin
          if (!seen_busy_q) drv_cnt_q <= drv_cnt_q + 1'b1;
          if (ws_busy_i) begin
            seen_busy_q <= 1'b1;
          end else if (seen_busy_q || drv_cnt_q == 2'(DRIVE_TIMEOUT - 1)) begin
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (latch_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_bank_o    = wr_bank_q;
  assign wr_grant_o   = grant_q;
  assign ws_start_o   = start_q;
  assign ws_bank_o    = ws_bank_q;
  assign ws_count_o   = ws_count_q;
  assign err_o        = err_q;
  assign sched_busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_neopix_frame_sched.sv
// Scoreboard bench for neopix_frame_sched: expected start/err events are queued by
// the stimulus thread and popped by a negedge monitor. Also covers NEOPIX_REFRESH_EN.
module tb_neopix_frame_sched;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       wr_begin_i = 1'b0;
  logic       wr_commit_i = 1'b0;
  logic [3:0] wr_count_i = '0;
  logic       ws_busy_i = 1'b0;
  logic       wr_bank_o, wr_grant_o, ws_start_o, ws_bank_o, err_o, sched_busy_o;
  logic [3:0] ws_count_o;

  typedef struct {
    int         cyc;
    logic       bank;
    logic [3:0] cnt;
    logic       wrBank;
  } startExp_t;

  startExp_t startQ[$];
  int        errQ[$];
  int        startLog[$];
  int        cycleCnt = 0;
  int        busyLen = 0;
  int        checks = 0;
  int        failures = 0;

  neopix_frame_sched #(
    .NUM_LEDS(8), .SYSTEM_CLOCK(1000000), .LATCH_US(80), .REFRESH_HZ(1000)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .wr_begin_i   (wr_begin_i),
    .wr_commit_i  (wr_commit_i),
    .wr_count_i   (wr_count_i),
    .wr_bank_o    (wr_bank_o),
    .wr_grant_o   (wr_grant_o),
    .ws_busy_i    (ws_busy_i),
    .ws_start_o   (ws_start_o),
    .ws_bank_o    (ws_bank_o),
    .ws_count_o   (ws_count_o),
    .err_o        (err_o),
    .sched_busy_o (sched_busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic waitUntil(input int target);
    while (cycleCnt < target) step(1);
  endtask

  task automatic applyStimulus(input logic doBegin, input logic doCommit, input logic [3:0] cnt);
    wr_begin_i  = doBegin;
    wr_commit_i = doCommit;
    wr_count_i  = cnt;
    step(1);
    wr_begin_i  = 1'b0;
    wr_commit_i = 1'b0;
    wr_count_i  = '0;
  endtask

  task automatic expectStart(input int cyc, input logic bank, input logic [3:0] cnt, input logic wrBank);
    startExp_t e;
    e.cyc = cyc; e.bank = bank; e.cnt = cnt; e.wrBank = wrBank;
    startQ.push_back(e);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_wrBank"}, wr_bank_o, 0);
    checkOutput({tag, "_wsBank"}, ws_bank_o, 1);
    checkOutput({tag, "_wsCount"}, ws_count_o, 0);
    checkOutput({tag, "_grant"}, wr_grant_o, 0);
    checkOutput({tag, "_start"}, ws_start_o, 0);
    checkOutput({tag, "_err"}, err_o, 0);
    checkOutput({tag, "_schedBusy"}, sched_busy_o, 0);
  endtask

  // Minimal ws2812 driver model: holds busy for busyLen cycles after each start.
  initial begin
    forever begin
      int len;
      @(posedge clk_i);
      len = busyLen;
      if (ws_start_o && len > 0) begin
        #1 ws_busy_i = 1'b1;
        repeat (len) @(posedge clk_i);
        #1 ws_busy_i = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a start or error pulse.
  always @(negedge clk_i) begin
    startExp_t e;
    checkOutput("bankInvariant", wr_bank_o ^ ws_bank_o, 1);
    if (ws_start_o) begin
      startLog.push_back(cycleCnt);
      if (startQ.size() == 0) begin
        checkOutput("unexpectedStart", 1, 0);
      end else begin
        e = startQ.pop_front();
        if (e.cyc >= 0) checkOutput("startCycle", cycleCnt, e.cyc);
        checkOutput("startWsBank", ws_bank_o, e.bank);
        checkOutput("startWsCount", ws_count_o, e.cnt);
        checkOutput("startWrBank", wr_bank_o, e.wrBank);
      end
    end
    if (err_o) begin
      if (errQ.size() == 0) checkOutput("unexpectedErr", 1, 0);
      else                  checkOutput("errCycle", cycleCnt, errQ.pop_front());
    end
  end

  initial begin
    #2000000;
    checkOutput("watchdog", 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int k, s1, s2, s3, s4, guard;
    step(3);
    checkReset("reset");
    reset_n_i = 1'b1;
    step(2);

`ifdef NEOPIX_REFRESH_EN
    $display("[TB] refresh: no starts while no frame has been committed");
    step(2100);
    applyStimulus(1, 0, 0);
    checkOutput("refGrant", wr_grant_o, 1);
    k = cycleCnt;
    expectStart(k + 3, 0, 4, 1);
    for (int i = 0; i < 4; i++) expectStart(-1, 0, 4, 1);
    applyStimulus(0, 1, 4);
    guard = 0;
    while (startLog.size() < 5 && guard < 6000) begin
      step(1);
      guard++;
    end
    checkOutput("refreshCountReached", startLog.size() >= 5, 1);
    if (startLog.size() >= 5) begin
      checkOutput("refreshPeriodA", startLog[3] - startLog[2], 1000);
      checkOutput("refreshPeriodB", startLog[4] - startLog[3], 1000);
    end
`else
    $display("[TB] frame 1: begin, commit 8");
    applyStimulus(1, 0, 0);
    checkOutput("t1Grant", wr_grant_o, 1);
    k = cycleCnt;
    expectStart(k + 3, 0, 8, 1);
    applyStimulus(0, 1, 8);
    checkOutput("t1GrantCleared", wr_grant_o, 0);
    checkOutput("t1SchedBusy", sched_busy_o, 0);
    step(1);
    checkOutput("t1SwapBusy", sched_busy_o, 1);
    waitUntil(k + 103);
    checkOutput("t1Idle", sched_busy_o, 0);

    $display("[TB] rejected commits");
    errQ.push_back(cycleCnt + 1);
    applyStimulus(0, 1, 5);
    step(3);
    applyStimulus(1, 0, 0);
    checkOutput("t2Grant", wr_grant_o, 1);
    errQ.push_back(cycleCnt + 1);
    applyStimulus(0, 1, 0);
    checkOutput("t2GrantCleared", wr_grant_o, 0);
    step(10);
    checkOutput("t2WsBank", ws_bank_o, 0);
    checkOutput("t2SchedBusy", sched_busy_o, 0);

    $display("[TB] commit during DRIVE, begin while pending, clamp");
    applyStimulus(1, 0, 0);
    k = cycleCnt;
    s1 = k + 3;
    expectStart(s1, 1, 3, 0);
    busyLen = 200;
    applyStimulus(0, 1, 3);
    waitUntil(s1 + 5);
    applyStimulus(1, 0, 0);
    checkOutput("t3GrantInDrive", wr_grant_o, 1);
    s2 = s1 + 1 + 200 + 82;
    expectStart(s2, 0, 5, 1);
    applyStimulus(0, 1, 5);
    waitUntil(s1 + 20);
    applyStimulus(1, 0, 0);
    checkOutput("t4GrantWhilePending", wr_grant_o, 0);
    busyLen = 10;
    waitUntil(s2 - 1);
    checkOutput("t4GrantBeforeStart", wr_grant_o, 0);
    waitUntil(s2);
    checkOutput("t4GrantAtStart", wr_grant_o, 1);
    waitUntil(s2 + 3);
    s3 = s2 + 1 + 10 + 82;
    expectStart(s3, 1, 8, 0);
    applyStimulus(0, 1, 12);
    busyLen = 0;
    waitUntil(s3 + 100);
    checkOutput("t4Idle", sched_busy_o, 0);

    $display("[TB] reset during LATCH");
    applyStimulus(1, 0, 0);
    k = cycleCnt;
    s4 = k + 3;
    expectStart(s4, 0, 2, 1);
    applyStimulus(0, 1, 2);
    waitUntil(s4 + 20);
    checkOutput("t6BusyInLatch", sched_busy_o, 1);
    reset_n_i = 1'b0;
    step(1);
    checkReset("t6Latch");
    step(1);
    reset_n_i = 1'b1;
    step(200);

    $display("[TB] reset during START");
    applyStimulus(1, 0, 0);
    k = cycleCnt;
    expectStart(k + 3, 0, 4, 1);
    applyStimulus(0, 1, 4);
    waitUntil(k + 3);
    checkOutput("t6StartHigh", ws_start_o, 1);
    reset_n_i = 1'b0;
    step(1);
    checkReset("t6Start");
    reset_n_i = 1'b1;
    step(200);
    checkOutput("t6Idle", sched_busy_o, 0);
`endif

    checkOutput("leftoverStarts", startQ.size(), 0);
    checkOutput("leftoverErrs", errQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
